wb_sram16_ctrl: RTL and testbench
=================================

// Module: wb_sram16_ctrl
// PURPOSE
//  Wishbone B3 classic slave that maps 32-bit bus accesses onto one external 256Kx16 async SRAM.
//  Each bus word becomes two sequenced 16-bit SRAM accesses (high half first, big-endian).
//  Drives CE/OE/WE/BLE/BHE with programmable cycle-count timing. Sits between the system bus arbiter and the board SRAM pins.
// PARAMETERS
//  AW        19  byte-address width used from wb_adr_i; SRAM word address = {adr[AW-1:2], half}
//  RD_CYC    2   clocks per 16-bit read half (>=1); data sampled at the last edge
//  WR_PULSE  2   clocks WE_n held low per 16-bit write half (>=1)
// PORTS
//  wb_clk_i      in   1   system clock
//  wb_rst_n_i    in   1   async reset, active low
//  wb_adr_i      in   AW  byte address
//  wb_dat_i      in   32  write data
//  wb_dat_o      out  32  read data, valid while wb_ack_o=1
//  wb_sel_i      in   4   byte selects ([3]=dat[31:24], lowest address)
//  wb_we_i       in   1   1=write
//  wb_cyc_i      in   1   cycle valid
//  wb_stb_i      in   1   strobe
//  wb_ack_o      out  1   one-cycle acknowledge
//  sram_adr_o    out  AW-1  SRAM halfword address
//  sram_dq_i     in   16  SRAM data in
//  sram_dq_o     out  16  SRAM data out
//  sram_dq_oe_o  out  1   1=drive pad
//  sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_ble_n_o, sram_bhe_n_o  out 1 each  SRAM strobes, active low
// BEHAVIOUR
//  Reset (async, immediate): all *_n_o=1, dq_oe=0, ack=0, dat_o=0, adr=0, FSM=IDLE. All outputs are registered; no comb paths from wb inputs to pins.
//  Accept: in IDLE with cyc&stb&!ack at edge E. Half0 = addr {adr,0}, dat[31:16], BHE_n=~sel[3], BLE_n=~sel[2].
//   Half1 = {adr,1}, dat[15:0], BHE_n=~sel[1], BLE_n=~sel[0]. Skip a half whose two sel bits are 0. sel=0000: no SRAM access; ack at E+1.
//  FSM: IDLE -> RD (RD_CYC clk/half) | WS (1 clk) -> WP (WR_PULSE clk) -> WH (1 clk) -> next half or ACK -> IDLE.
//  READ: CE_n=OE_n=0 from E through the last sample; addr changes at the half boundary with CE/OE held low. dq_oe=0 throughout.
//   Sample sram_dq_i into the matching dat_o half. Both halves: ack=1 in cycle E+2*RD_CYC.
//   Unselected bytes of dat_o read as 0.
//  WRITE: WS: CE_n=0, addr/data/BxE valid, dq_oe=1, WE_n=1. WP: WE_n=0. WH: WE_n=1, data/addr held. OE_n=1 for the whole write.
//   Both halves: ack in cycle E+2*(WR_PULSE+2).
//  ACK state: ack=1 for exactly one cycle. CE_n=OE_n=WE_n=1, dq_oe=0 (bus turnaround). Return to IDLE.
//   IDLE lasts >=1 cycle, so back-to-back requests always see >=1 clk with all strobes high.
//  Abort: cyc_i drops mid-transfer -> finish the current half (a WE pulse is never truncated). Then go straight to IDLE, no ack.
//  stb/inputs are sampled only at accept; changes during a transfer are ignored (registered copy).
//  Timing counter is a down-counter loaded per state; the width fits max(RD_CYC,WR_PULSE).
// STRUCTURE
//  Include file sram_ctrl_defines.v: FSM state encodings (IDLE,RD,WS,WP,WH,ACK), default timing values.
//  Single sub-module sram_phase_timer: loadable down-counter, load/value/done. Used for the RD and WP phases.
//  Top holds the FSM, request capture regs, pin output regs and the read-data assembly.
// TESTING
//  Bench: this controller plus a behavioural async 256Kx16 SRAM model on a tristate bus, 20 ns clock, timing-violation checks enabled.
//  1 Write 0xDEADBEEF @0x100, sel=1111 -> SRAM[0x80]=0xDEAD, [0x81]=0xBEEF; ack at E+8 (defaults); WE_n low 2 clk per half.
//  2 Read @0x100 after test 1 -> dat_o=0xDEADBEEF with ack at E+4; OE_n low 4 clk; dq_oe never 1.
//  3 Write 0x11223344, sel=0100 -> only half0 runs, BHE_n=1, BLE_n=0; read back whole word -> 0xDE22BEEF.
//  4 sel=0000 write -> ack at E+1, CE_n stays 1; next read/write back-to-back -> >=1 clk with all strobes high.
//  5 Drop cyc in cycle E+1 of a write -> half0 completes (full WE pulse), no half1, no ack, FSM IDLE.
//  6 Assert wb_rst_n_i=0 during WP -> WE_n, CE_n go 1 and dq_oe goes 0 in the same instant; no ack follows release.

Source files
------------

// File: rtl/wb_sram16_ctrl_pkg.sv
// Shared types and defaults for the Wishbone-to-16-bit async SRAM controller.
// Holds the FSM state encoding, default timing values and the counter width helper.
package wb_sram16_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWs,
        StWp,
        StWh,
        StAck
    } state_e;

    localparam int unsigned DefAw      = 19;
    localparam int unsigned DefRdCyc   = 2;
    localparam int unsigned DefWrPulse = 2;

    // The timer is loaded with (cycles - 1), so it only needs to hold max_cyc - 1.
    function automatic int unsigned cnt_width(input int unsigned max_cyc);
        return (max_cyc <= 2) ? 1 : $clog2(max_cyc);
    endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Loadable down-counter that times the RD and WP phases of an SRAM half access.
// done is high while the count is zero; the count stops at zero.
module sram_phase_timer #(
    parameter int unsigned Width = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [Width-1:0] value,
    output logic             done
);

    logic [Width-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= value;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/wb_sram16_ctrl.sv
// Wishbone B3 classic slave splitting each 32-bit access into two 16-bit async SRAM accesses,
// high half first. All SRAM pins and bus outputs come straight from registers.
module wb_sram16_ctrl
    import wb_sram16_ctrl_pkg::*;
#(
    parameter int unsigned AW       = DefAw,
    parameter int unsigned RD_CYC   = DefRdCyc,
    parameter int unsigned WR_PULSE = DefWrPulse
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n_i,
    input  logic [AW-1:0] wb_adr_i,
    input  logic [31:0]   wb_dat_i,
    output logic [31:0]   wb_dat_o,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    output logic          wb_ack_o,
    output logic [AW-2:0] sram_adr_o,
    input  logic [15:0]   sram_dq_i,
    output logic [15:0]   sram_dq_o,
    output logic          sram_dq_oe_o,
    output logic          sram_ce_n_o,
    output logic          sram_oe_n_o,
    output logic          sram_we_n_o,
    output logic          sram_ble_n_o,
    output logic          sram_bhe_n_o
);

    localparam int unsigned MaxCyc = (RD_CYC > WR_PULSE) ? RD_CYC : WR_PULSE;
    localparam int unsigned CntW   = cnt_width(MaxCyc);

    state_e          state_q, state_d;
    logic            half_q, half_d, h1_pend_q, h1_pend_d;
    logic            we_q, we_d, abort_q, abort_d, ack_q, ack_d;
    logic [3:0]      sel_q, sel_d;
    logic [AW-3:0]   adr_q, adr_d;
    logic [31:0]     wdat_q, wdat_d, dat_q, dat_d;
    logic            ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic            ble_n_q, ble_n_d, bhe_n_q, bhe_n_d, dq_oe_q, dq_oe_d;
    logic [AW-2:0]   sadr_q, sadr_d;
    logic [15:0]     dq_q, dq_d;

    logic            tmr_load, tmr_done;
    logic [CntW-1:0] tmr_val;
    logic            start_go, start_half, end_half, aborting, src_we;
    logic [3:0]      src_sel;
    logic [AW-3:0]   src_adr;
    logic [31:0]     src_dat;
    logic [1:0]      cur_sel;
    logic [15:0]     rd_masked;
    logic            unused_adr;

    assign unused_adr = ^wb_adr_i[1:0];

    sram_phase_timer #(
        .Width(CntW)
    ) u_timer (
        .clk  (wb_clk_i),
        .rst_n(wb_rst_n_i),
        .load (tmr_load),
        .value(tmr_val),
        .done (tmr_done)
    );

    always_comb begin
        state_d   = state_q;
        half_d    = half_q;
        h1_pend_d = h1_pend_q;
        we_d      = we_q;
        sel_d     = sel_q;
        adr_d     = adr_q;
        wdat_d    = wdat_q;
        dat_d     = dat_q;
        abort_d   = abort_q;
        ack_d     = 1'b0;
        ce_n_d    = ce_n_q;
        oe_n_d    = oe_n_q;
        we_n_d    = we_n_q;
        ble_n_d   = ble_n_q;
        bhe_n_d   = bhe_n_q;
        dq_oe_d   = dq_oe_q;
        sadr_d    = sadr_q;
        dq_d      = dq_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        start_go  = 1'b0;
        start_half = 1'b0;
        end_half  = 1'b0;
        src_we    = we_q;
        src_sel   = sel_q;
        src_adr   = adr_q;
        src_dat   = wdat_q;
        aborting  = abort_q | ~wb_cyc_i;
        cur_sel   = half_q ? sel_q[1:0] : sel_q[3:2];
        rd_masked = sram_dq_i & {{8{cur_sel[1]}}, {8{cur_sel[0]}}};

        unique case (state_q)
            StIdle: begin
                if (wb_cyc_i && wb_stb_i && !ack_q) begin
                    we_d      = wb_we_i;
                    sel_d     = wb_sel_i;
                    adr_d     = wb_adr_i[AW-1:2];
                    wdat_d    = wb_dat_i;
                    dat_d     = '0;
                    abort_d   = 1'b0;
                    src_we    = wb_we_i;
                    src_sel   = wb_sel_i;
                    src_adr   = wb_adr_i[AW-1:2];
                    src_dat   = wb_dat_i;
                    h1_pend_d = (|wb_sel_i[3:2]) && (|wb_sel_i[1:0]);
                    if (|wb_sel_i[3:2]) begin
                        start_go = 1'b1;
                    end else if (|wb_sel_i[1:0]) begin
                        start_go   = 1'b1;
                        start_half = 1'b1;
                    end else begin
                        // Nothing selected: one dead cycle with pins idle, then ack.
                        state_d = StWh;
                    end
                end
            end
            StRd: begin
                abort_d = aborting;
                if (tmr_done) begin
                    if (half_q) dat_d[15:0] = rd_masked;
                    else        dat_d[31:16] = rd_masked;
                    end_half = 1'b1;
                end
            end
            StWs: begin
                abort_d  = aborting;
                state_d  = StWp;
                we_n_d   = 1'b0;
                tmr_load = 1'b1;
                tmr_val  = CntW'(WR_PULSE - 1);
            end
            StWp: begin
                abort_d = aborting;
                if (tmr_done) begin
                    state_d = StWh;
                    we_n_d  = 1'b1;
                end
            end
            StWh:    end_half = 1'b1;
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (end_half) begin
            if (!aborting && h1_pend_q) begin
                h1_pend_d  = 1'b0;
                start_go   = 1'b1;
                start_half = 1'b1;
            end else begin
                state_d = aborting ? StIdle : StAck;
                ack_d   = ~aborting;
                ce_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                we_n_d  = 1'b1;
                ble_n_d = 1'b1;
                bhe_n_d = 1'b1;
                dq_oe_d = 1'b0;
            end
        end

        if (start_go) begin
            half_d  = start_half;
            state_d = src_we ? StWs : StRd;
            sadr_d  = {src_adr, start_half};
            bhe_n_d = ~(start_half ? src_sel[1] : src_sel[3]);
            ble_n_d = ~(start_half ? src_sel[0] : src_sel[2]);
            dq_d    = start_half ? src_dat[15:0] : src_dat[31:16];
            ce_n_d  = 1'b0;
            oe_n_d  = src_we;
            we_n_d  = 1'b1;
            dq_oe_d = src_we;
            if (!src_we) begin
                tmr_load = 1'b1;
                tmr_val  = CntW'(RD_CYC - 1);
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q   <= StIdle;
            half_q    <= 1'b0;
            h1_pend_q <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            adr_q     <= '0;
            wdat_q    <= '0;
            dat_q     <= '0;
            abort_q   <= 1'b0;
            ack_q     <= 1'b0;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            ble_n_q   <= 1'b1;
            bhe_n_q   <= 1'b1;
            dq_oe_q   <= 1'b0;
            sadr_q    <= '0;
            dq_q      <= '0;
        end else begin
            state_q   <= state_d;
            half_q    <= half_d;
            h1_pend_q <= h1_pend_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            wdat_q    <= wdat_d;
            dat_q     <= dat_d;
            abort_q   <= abort_d;
            ack_q     <= ack_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            ble_n_q   <= ble_n_d;
            bhe_n_q   <= bhe_n_d;
            dq_oe_q   <= dq_oe_d;
            sadr_q    <= sadr_d;
            dq_q      <= dq_d;
        end
    end

    assign wb_dat_o     = dat_q;
    assign wb_ack_o     = ack_q;
    assign sram_adr_o   = sadr_q;
    assign sram_dq_o    = dq_q;
    assign sram_dq_oe_o = dq_oe_q;
    assign sram_ce_n_o  = ce_n_q;
    assign sram_oe_n_o  = oe_n_q;
    assign sram_we_n_o  = we_n_q;
    assign sram_ble_n_o = ble_n_q;
    assign sram_bhe_n_o = bhe_n_q;

endmodule

// File: tb/tb_wb_sram16_ctrl.sv
// Bench for wb_sram16_ctrl: behavioural 256Kx16 async SRAM, strobe timing monitor and a
// word-level reference memory driving directed plus randomized bus traffic.
module tb_wb_sram16_ctrl;

    localparam int unsigned AW       = 19;
    localparam int unsigned RD_CYC   = 2;
    localparam int unsigned WR_PULSE = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] wb_adr = '0;
    logic [31:0]   wb_dat = '0;
    logic [31:0]   wb_dat_o;
    logic [3:0]    wb_sel = '0;
    logic          wb_we = 1'b0, wb_cyc = 1'b0, wb_stb = 1'b0;
    logic          wb_ack;
    logic [AW-2:0] sram_adr;
    logic [15:0]   sram_dq_i, sram_dq_o;
    logic          dq_oe, ce_n, oe_n, we_n, ble_n, bhe_n;

    always #10 clk = ~clk;

    wb_sram16_ctrl #(
        .AW      (AW),
        .RD_CYC  (RD_CYC),
        .WR_PULSE(WR_PULSE)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .wb_adr_i    (wb_adr),
        .wb_dat_i    (wb_dat),
        .wb_dat_o    (wb_dat_o),
        .wb_sel_i    (wb_sel),
        .wb_we_i     (wb_we),
        .wb_cyc_i    (wb_cyc),
        .wb_stb_i    (wb_stb),
        .wb_ack_o    (wb_ack),
        .sram_adr_o  (sram_adr),
        .sram_dq_i   (sram_dq_i),
        .sram_dq_o   (sram_dq_o),
        .sram_dq_oe_o(dq_oe),
        .sram_ce_n_o (ce_n),
        .sram_oe_n_o (oe_n),
        .sram_we_n_o (we_n),
        .sram_ble_n_o(ble_n),
        .sram_bhe_n_o(bhe_n)
    );

    // Async SRAM: write latched on the rising edge of WE_n, read driven while CE/OE low.
    logic [15:0] sram_mem [0:262143];
    assign sram_dq_i = (!ce_n && !oe_n && we_n) ? sram_mem[sram_adr] : 16'hxxxx;

    always @(posedge we_n) begin
        if (ce_n === 1'b0) begin
            if (!ble_n) sram_mem[sram_adr][7:0]  <= sram_dq_o[7:0];
            if (!bhe_n) sram_mem[sram_adr][15:8] <= sram_dq_o[15:8];
        end
    end

    // Strobe monitor: running totals plus write-pulse and bus-contention rule checks.
    int tot_ce = 0, tot_oe = 0, tot_we = 0, tot_dqoe = 0, we_pulses = 0, viol = 0, we_run = 0;
    logic we_prev = 1'b0;
    logic [AW-2:0] prev_adr = '0;
    logic [15:0] prev_dq = '0;

    always @(negedge clk) begin
        bit v;
        v = 1'b0;
        if (!rst_n) begin
            we_run  <= 0;
            we_prev <= 1'b0;
        end else begin
            tot_ce   <= tot_ce + {31'd0, ~ce_n};
            tot_oe   <= tot_oe + {31'd0, ~oe_n};
            tot_we   <= tot_we + {31'd0, ~we_n};
            tot_dqoe <= tot_dqoe + {31'd0, dq_oe};
            we_prev  <= ~we_n;
            prev_adr <= sram_adr;
            prev_dq  <= sram_dq_o;
            if (dq_oe && !oe_n) v = 1'b1;
            if (!we_n) begin
                we_run <= we_run + 1;
                if (ce_n || !dq_oe || !oe_n) v = 1'b1;
                if (we_prev && (sram_adr != prev_adr || sram_dq_o != prev_dq)) v = 1'b1;
            end else begin
                we_run <= 0;
                if (we_prev) begin
                    we_pulses <= we_pulses + 1;
                    if (we_run != int'(WR_PULSE)) v = 1'b1;
                end
            end
            if (v) viol <= viol + 1;
        end
    end

    int n_checks = 0, n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Word-level reference memory
    logic [31:0] ref_mem [int];

    function automatic logic [31:0] bmask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    function automatic logic [31:0] ref_rd(input int w);
        return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    endfunction

    task automatic ref_wr(input int w, input logic [31:0] dat, input logic [3:0] sel);
        ref_mem[w] = (ref_rd(w) & ~bmask(sel)) | (dat & bmask(sel));
    endtask

    function automatic int exp_lat(input logic we, input logic [3:0] sel);
        int n;
        n = int'(|sel[3:2]) + int'(|sel[1:0]);
        if (n == 0) return 1;
        return we ? n * int'(WR_PULSE + 2) : n * int'(RD_CYC);
    endfunction

    int          x_lat;
    logic [31:0] x_rdat;
    logic [4:0]  x_first;
    logic [1:0]  x_bxe;

    // Called right after a negedge; x_lat = cycles from the accept edge to the ack cycle.
    task automatic xfer(input logic we, input logic [AW-1:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel);
        wb_we = we; wb_adr = adr; wb_dat = dat; wb_sel = sel; wb_cyc = 1'b1; wb_stb = 1'b1;
        x_lat = -1; x_rdat = '0; x_first = '0; x_bxe = 2'b11;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 0) x_first = {ce_n, oe_n, we_n, ble_n, bhe_n};
            if (!we_n) x_bxe = {bhe_n, ble_n};
            if (wb_ack) begin
                x_lat  = i;
                x_rdat = wb_dat_o;
                break;
            end
        end
        wb_cyc = 1'b0; wb_stb = 1'b0;
    endtask

    int          s_ce, s_oe, s_we, s_dqoe, ack_seen;
    logic [15:0] keep_lo;
    logic [31:0] rdat;
    logic        r_we;
    logic [3:0]  r_sel;
    int          r_w;

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_pins", {25'd0, ce_n, oe_n, we_n, ble_n, bhe_n, dq_oe, wb_ack}, 32'h7C);
        chk("reset_dat", wb_dat_o, 32'h0);
        chk("reset_adr", {14'd0, sram_adr}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Prefill the random window and the abort word.
        for (int w = 'h40; w < 'h50; w++) begin
            rdat = $urandom;
            xfer(1'b1, AW'(w << 2), rdat, 4'hF);
            ref_wr(w, rdat, 4'hF);
            @(negedge clk);
        end
        xfer(1'b1, AW'('h400), 32'hA5A5_5A5A, 4'hF);
        ref_wr('h100, 32'hA5A5_5A5A, 4'hF);
        @(negedge clk);

        // 1: full write
        s_ce = tot_ce; s_we = tot_we; s_oe = tot_oe;
        xfer(1'b1, AW'('h100), 32'hDEAD_BEEF, 4'hF);
        ref_wr('h40, 32'hDEAD_BEEF, 4'hF);
        chk("t1_lat", x_lat, 8);
        chk("t1_mem_hi", {16'd0, sram_mem[18'h80]}, 32'hDEAD);
        chk("t1_mem_lo", {16'd0, sram_mem[18'h81]}, 32'hBEEF);
        chk("t1_we_low", tot_we - s_we, 2 * WR_PULSE);
        chk("t1_ce_low", tot_ce - s_ce, 2 * (WR_PULSE + 2));
        chk("t1_oe_low", tot_oe - s_oe, 0);
        @(negedge clk);

        // 2: full read
        s_oe = tot_oe; s_dqoe = tot_dqoe;
        xfer(1'b0, AW'('h100), 32'h0, 4'hF);
        chk("t2_lat", x_lat, 4);
        chk("t2_dat", x_rdat, 32'hDEAD_BEEF);
        chk("t2_oe_low", tot_oe - s_oe, 2 * RD_CYC);
        chk("t2_dq_oe", tot_dqoe - s_dqoe, 0);
        @(negedge clk);

        // 3: single-byte write, half0 only
        s_we = tot_we;
        xfer(1'b1, AW'('h100), 32'h1122_3344, 4'b0100);
        ref_wr('h40, 32'h1122_3344, 4'b0100);
        chk("t3_lat", x_lat, 4);
        chk("t3_bxe", {30'd0, x_bxe}, 32'h2);
        chk("t3_we_low", tot_we - s_we, WR_PULSE);
        @(negedge clk);
        xfer(1'b0, AW'('h100), 32'h0, 4'hF);
        chk("t3_rdback", x_rdat, 32'hDE22_BEEF);
        @(negedge clk);

        // 4: empty select, then a back-to-back read
        s_ce = tot_ce;
        xfer(1'b1, AW'('h100), 32'hFFFF_FFFF, 4'h0);
        chk("t4_lat", x_lat, 1);
        chk("t4_ce_low", tot_ce - s_ce, 0);
        xfer(1'b0, AW'('h100), 32'h0, 4'hF);
        chk("t4_b2b_gap", {27'd0, x_first}, 32'h1F);
        chk("t4_b2b_lat", x_lat, 5);
        chk("t4_b2b_dat", x_rdat, ref_rd('h40));
        @(negedge clk);

        // 5: cyc dropped in cycle E+1 of a write
        s_ce = tot_ce; s_we = tot_we; keep_lo = sram_mem[18'h201];
        wb_we = 1'b1; wb_adr = AW'('h400); wb_dat = 32'h1357_9BDF; wb_sel = 4'hF;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        @(negedge clk);
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        ack_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (wb_ack) ack_seen++;
        end
        ref_wr('h100, 32'h1357_9BDF, 4'b1100);
        chk("t5_no_ack", ack_seen, 0);
        chk("t5_we_low", tot_we - s_we, WR_PULSE);
        chk("t5_ce_low", tot_ce - s_ce, WR_PULSE + 2);
        chk("t5_half1_kept", {16'd0, sram_mem[18'h201]}, {16'd0, keep_lo});
        xfer(1'b0, AW'('h400), 32'h0, 4'hF);
        chk("t5_idle_lat", x_lat, 4);
        chk("t5_rdback", x_rdat, ref_rd('h100));
        @(negedge clk);

        // Randomized traffic against the reference memory
        for (int i = 0; i < 40; i++) begin
            r_w   = 'h40 + int'($urandom_range(0, 15));
            r_we  = 1'($urandom_range(0, 1));
            r_sel = 4'($urandom_range(0, 15));
            rdat  = $urandom;
            xfer(r_we, AW'(r_w << 2), rdat, r_sel);
            chk($sformatf("rnd%0d_lat", i), x_lat, exp_lat(r_we, r_sel));
            if (r_we) ref_wr(r_w, rdat, r_sel);
            else chk($sformatf("rnd%0d_dat", i), x_rdat, ref_rd(r_w) & bmask(r_sel));
            @(negedge clk);
        end

        // 6: async reset during the write pulse
        wb_we = 1'b1; wb_adr = AW'('h800); wb_dat = 32'h0F0F_F0F0; wb_sel = 4'hF;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #5;
        chk("t6_in_wp", {31'd0, we_n}, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_pins", {29'd0, we_n, ce_n, dq_oe}, 32'h6);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        s_ce = tot_ce; ack_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (wb_ack) ack_seen++;
        end
        chk("t6_no_ack", ack_seen, 0);
        chk("t6_ce_idle", tot_ce - s_ce, 0);

        chk("timing_viol", viol, 0);
        chk("we_pulses_seen", {31'd0, we_pulses != 0}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
